// File: rtl/man_pkg.sv
// man_pkg: definitions shared by the Manchester decoder files.
//   man_state_e      : FSM state encoding. The same values appear on state_out.
//   POL_THOMAS       : a falling mid-bit edge decodes as 1.
//   POL_IEEE         : a rising mid-bit edge decodes as 1.
//   TOL_SHIFT        : sets the sync tolerance to half_len >> TOL_SHIFT (+-1/4).
package man_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SYNC_LO   = 3'd1,
        SYNC_HI   = 3'd2,
        MASK      = 3'd3,
        WAIT_EDGE = 3'd4
    } man_state_e;

    localparam bit POL_THOMAS = 1'b0;
    localparam bit POL_IEEE   = 1'b1;

    localparam int TOL_SHIFT = 2;

endpackage

// File: rtl/man_decoder_param_if.sv
// man_decoder_param_if: word handshake between the decoder and its consumer.
//   data_out   : decoded word. It is held stable while data_valid is high.
//   data_valid : a word is on offer.
//   data_ready : the consumer takes the word on any cycle where valid && ready.
//                Once data_valid is high it stays high until that cycle.
// Modports:
//   master : the decoder side.
//   slave  : the consumer side.
interface man_decoder_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/man_out_reg.sv
// man_out_reg: single-entry output register for decoded words.
//   clk, rst  : clock and asynchronous active-high reset.
//   push      : a complete word is presented this cycle.
//   push_data : the word being presented.
//   bus       : valid/ready word interface (master side).
//   overrun   : one-cycle pulse when a pushed word is dropped.
//
// A push is accepted when the register is empty, or when the register is
// being drained in the same cycle. In any other case the word is lost and
// the registered contents are left unchanged.
module man_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DATA_W-1:0]   push_data,
    man_decoder_param_if.master bus,
    output logic                overrun
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (push && (!bus.data_valid || bus.data_ready)) begin
                bus.data_out   <= push_data;
                bus.data_valid <= 1'b1;
            end else begin
                if (bus.data_valid && bus.data_ready) begin
                    bus.data_valid <= 1'b0;
                end
                // This branch only sees a push when the register is full
                // and is not being drained, so the push is dropped.
                overrun <= push;
            end
        end
    end

endmodule

// File: rtl/man_decoder_param.sv
// man_decoder_param: oversampled Manchester receiver.
// The sync preamble gives the bit timing. Each frame yields one DATA_W-bit
// word, received MSB first.
//   clk, rst   : sampling clock (>= 4x bit rate), asynchronous active-high reset.
//   din        : synchronised Manchester line. The line idles high.
//   bus        : valid/ready word output (master side).
//   frame_err  : one-cycle pulse on a sync, timing or parity violation.
//   overrun    : one-cycle pulse when a completed word is dropped.
//   busy       : high in every state except IDLE.
//   state_out  : current FSM state (man_state_e encoding).
// Optional build macro MAN_PARITY_EN:
//   Each frame carries one more bit, an even parity bit over the data bits.
//   A frame whose parity fails is dropped and raises frame_err.
module man_decoder_param
    import man_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 8,
    parameter int MIN_HALF = 2,
    parameter int MAX_HALF = 200,
    parameter bit POLARITY = POL_THOMAS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
    man_decoder_param_if.master bus,
    output logic                frame_err,
    output logic                overrun,
    output logic                busy,
    output logic [2:0]          state_out
);

`ifdef MAN_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int BC_W = $clog2(NBITS + 1);

    localparam logic [CNT_W:0]  MIN_C    = (CNT_W+1)'(MIN_HALF);
    localparam logic [CNT_W:0]  MAX_C    = (CNT_W+1)'(MAX_HALF);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(NBITS - 1);

    man_state_e        state, state_n;
    logic              din_q;
    logic [CNT_W:0]    half_cnt, half_cnt_n;
    logic [CNT_W-1:0]  half_len, half_len_n;
    logic [CNT_W:0]    mask_cnt, mask_cnt_n;
    logic [CNT_W-1:0]  to_cnt, to_cnt_n;
    logic [BC_W-1:0]   bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] word, word_n, word_sh;
    logic              err_n, push;
    logic [DATA_W-1:0] push_data;

    // Timing limits are kept one bit wider than CNT_W. This keeps 1.25x and
    // 1.5x of half_len from wrapping.
    logic [CNT_W:0] half_ext, tol, lo_lim, hi_lim, mask_load;
    logic           bit_in, edge_seen;

    assign half_ext  = {1'b0, half_len};
    assign tol       = half_ext >> TOL_SHIFT;
    assign lo_lim    = half_ext - tol;
    assign hi_lim    = half_ext + tol;
    assign mask_load = half_ext + (half_ext >> 1);

    assign bit_in    = (POLARITY == POL_IEEE) ? din : ~din;
    assign edge_seen = din ^ din_q;

    always_comb begin
        word_sh    = word << 1;
        word_sh[0] = bit_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            din_q     <= 1'b1;   // line history starts at the idle level
            half_cnt  <= '0;
            half_len  <= '0;
            mask_cnt  <= '0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            word      <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            din_q     <= din;
            half_cnt  <= half_cnt_n;
            half_len  <= half_len_n;
            mask_cnt  <= mask_cnt_n;
            to_cnt    <= to_cnt_n;
            bit_cnt   <= bit_cnt_n;
            word      <= word_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        half_cnt_n = half_cnt;
        half_len_n = half_len;
        mask_cnt_n = mask_cnt;
        to_cnt_n   = to_cnt;
        bit_cnt_n  = bit_cnt;
        word_n     = word;
        err_n      = 1'b0;
        push       = 1'b0;
        push_data  = word_sh;

        case (state)
            IDLE: begin
                if (din_q && !din) begin
                    state_n    = SYNC_LO;
                    half_cnt_n = (CNT_W+1)'(1);
                end
            end

            SYNC_LO: begin
                if (!din) begin
                    if (half_cnt >= MAX_C) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        half_cnt_n = half_cnt + (CNT_W+1)'(1);
                    end
                end else if (half_cnt >= MIN_C && half_cnt <= MAX_C) begin
                    half_len_n = half_cnt[CNT_W-1:0];
                    half_cnt_n = (CNT_W+1)'(1);
                    state_n    = SYNC_HI;
                end else begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end

            SYNC_HI: begin
                if (din) begin
                    // Stop at the upper limit so a stuck-high line is not
                    // held in SYNC_HI forever.
                    if (half_cnt >= hi_lim) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        half_cnt_n = half_cnt + (CNT_W+1)'(1);
                    end
                end else if (half_cnt >= lo_lim && half_cnt <= hi_lim) begin
                    // This falling edge is the first mid-bit reference.
                    // It only sets the timing and carries no data.
                    mask_cnt_n = mask_load;
                    bit_cnt_n  = '0;
                    word_n     = '0;
                    state_n    = MASK;
                end else begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end

            MASK: begin
                // Blanks 3/4 of a bit period after each mid-bit edge, which
                // hides the bit-boundary transition.
                if (mask_cnt <= (CNT_W+1)'(1)) begin
                    to_cnt_n = '0;
                    state_n  = WAIT_EDGE;
                end else begin
                    mask_cnt_n = mask_cnt - (CNT_W+1)'(1);
                end
            end

            WAIT_EDGE: begin
                if (edge_seen) begin
                    bit_cnt_n  = bit_cnt + BC_W'(1);
                    mask_cnt_n = mask_load;
                    state_n    = MASK;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = IDLE;
`ifdef MAN_PARITY_EN
                        // Here the last bit is the parity bit and is not
                        // shifted into the word.
                        if (bit_in == ^word) begin
                            push      = 1'b1;
                            push_data = word;
                        end else begin
                            err_n = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                    end else begin
                        word_n = word_sh;
                    end
                end else if (to_cnt == half_len) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    to_cnt_n = to_cnt + CNT_W'(1);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    man_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .bus       (bus),
        .overrun   (overrun)
    );

    assign busy      = (state != IDLE);
    assign state_out = state;

endmodule

// File: doc/man_decoder_param.md
Name: man_decoder_param

Overview:
- Parametrised successor Manchester receiver: oversampled serial line in, one decoded word per frame out.
- Measures the bit period from a sync preamble and decodes DATA_W bits, MSB first.
- Detects timing and encoding errors and delivers words over a valid/ready handshake.
- Sits between the line-side pin (already synchronised upstream) and the word-level consumer.

Parameters:
- DATA_W, 8, decoded bits per frame (1..32).
- CNT_W, 8, width of half-bit measurement and timing counters.
- MIN_HALF, 2, minimum legal measured half-bit length in clk cycles.
- MAX_HALF, 200, maximum legal measured half-bit length in clk cycles; must fit CNT_W.
- POLARITY, 0, 0: falling mid-bit edge = 1 (G.E. Thomas); 1: rising mid-bit edge = 1 (IEEE 802.3).

Ports:
- clk  input  1  sampling clock, at least 4x the line bit rate.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  Manchester line; idles high.
- data_out  output  DATA_W  decoded word; stable while data_valid=1.
- data_valid  output  1  word available.
- data_ready  input  1  consumer accepts word when valid&&ready.
- frame_err  output  1  one-cycle pulse on sync or timing violation.
- overrun  output  1  one-cycle pulse when a completed word is dropped.
- busy  output  1  high in any state except IDLE.
- state_out  output  3  current state encoding, for debug LEDs.

Behaviour:
- Reset values: data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE.
- All counters, flags and the shift register are cleared on reset.
- States: IDLE, SYNC_LO, SYNC_HI, MASK, WAIT_EDGE.
- IDLE: waits for din 1->0.
  - Go to SYNC_LO with half_cnt=1.
- SYNC_LO: increments half_cnt each cycle while din=0.
  - On din=1: if MIN_HALF<=half_cnt<=MAX_HALF, latch half_len=half_cnt and go to SYNC_HI.
  - Otherwise pulse frame_err and go to IDLE.
  - If half_cnt would exceed MAX_HALF while din=0: pulse frame_err, go to IDLE.
- SYNC_HI: counts while din=1.
  - The 1->0 edge at count within half_len±half_len/4 is the first data mid-bit reference.
  - Out of tolerance: frame_err, go to IDLE.
  - In tolerance: load mask_cnt = half_len + half_len/2 (3/4 bit period) and go to MASK.
  - This first edge is a timing reference only; no data bit is recorded.
- MASK: ignores all din edges; decrements mask_cnt; on mask_cnt==0 go to WAIT_EDGE with to_cnt=0.
- WAIT_EDGE: the first din change is the mid-bit edge.
  - Shift-in order is MSB first: word <= {word[DATA_W-2:0], bit}.
  - bit = POLARITY ? din_new : ~din_new.
  - bit_cnt++; reload mask_cnt; go to MASK.
  - After bit_cnt reaches DATA_W, go to IDLE instead and deliver the word.
- Timeout: if to_cnt reaches half_len (no edge by 5/4 bit after the last mid-bit edge), pulse frame_err, discard the partial word, go to IDLE.
- Width rule: half_len + half_len/2 is computed in CNT_W+1 bits, with no truncation.
- Delivery:
  - Output register empty, or valid&&ready in the same cycle: data_out <= word and data_valid=1 in the cycle after the final edge (latency 1 clk from the last mid-bit edge).
  - Output register full and not being accepted: word dropped, overrun pulses, data_out unchanged.
- data_valid falls the cycle after valid&&ready, unless a new word is loaded that same cycle.
- Reset mid-frame: immediate return to IDLE; partial word lost; no error pulse.
- din glitches inside MASK are invisible by design; glitches in IDLE shorter than MIN_HALF produce frame_err.

Optional Feature:
- MAN_PARITY_EN defined:
  - Each frame carries DATA_W+1 bits; the last bit is even parity over the data bits.
  - The parity bit is not shifted into data_out.
  - On mismatch, pulse frame_err and drop the word (no data_valid, no overrun).
- MAN_PARITY_EN undefined: exactly DATA_W bits per frame; no parity logic is generated.

Decomposition:
- Shared package man_pkg holds:
  - state enumeration constants (IDLE=3'd0, SYNC_LO=3'd1, SYNC_HI=3'd2, MASK=3'd3, WAIT_EDGE=3'd4);
  - polarity constants;
  - the tolerance shift amount (2, i.e. ±1/4).
- One natural sub-module, man_out_reg: single-entry output register with valid/ready handshake and overrun detection.

Test Plan:
- Reset then idle-high din: data_valid=0, busy=0, frame_err=0, state_out=IDLE.
- POLARITY=0, half_len=4, frame 8'hA5 sent with data_ready=1 -> data_out=8'hA5, data_valid=1 for one cycle, 1 clk after the last edge.
- Same stream with POLARITY=1 -> data_out=8'h5A.
- Sync low pulse of 1 clk (below MIN_HALF=2) -> frame_err pulse, return to IDLE, no data_valid.
- Line stuck high after 3 data bits (half_len=4) -> frame_err exactly 5 clk after MASK expiry; partial word discarded.
- data_ready=0, two frames 8'h11 then 8'h22 -> data_out stays 8'h11, overrun pulses once.
  - Then raise data_ready: valid drops.
  - Next frame 8'h33 is delivered.
- Build with MAN_PARITY_EN: 8'h03 with parity 0 -> delivered; 8'h03 with parity 1 -> frame_err, no data_valid.
